// File: rtl/sparse_pos_loader_pkg.sv
// Shared constants and op codes for the sparse position RAM loader.
package sparse_pos_loader_pkg;

  localparam int LANES  = 8;
  localparam int POS_W  = 16;
  localparam int DEPTH  = 75;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int LANE_W = $clog2(LANES);
  localparam int DATA_W = LANES * POS_W;

  // Tag bit OR-ed with the slot index to mark a padding entry.
  localparam logic [POS_W-1:0] DUMMY_MARK = {1'b1, {(POS_W-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_FILL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

endpackage

// File: rtl/sparse_pos_loader_mem.sv
// Single-port position RAM with one-cycle registered read.
module mem_single #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 75,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write on we, otherwise register the addressed word for the next cycle.
  // NOTE: the array has no reset so it maps onto RAM macros; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem[addr_i] <= wdata_i;
      else      rdata_o     <= mem[addr_i];
    end
  end

endmodule

// File: rtl/sparse_pos_loader.sv
// Command-driven writer/reader/padder for the sparse-polynomial position RAM.
module sparse_pos_loader
  import sparse_pos_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [CNT_W-1:0]  rsp_count_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_READ, ST_RDRAIN, ST_FILL, ST_RESP
  } state_e;

  // Slot arithmetic is one bit wider than the address so addr+j never wraps.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LANES_X = (ADDR_W+1)'(LANES);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]   rsp_count_q, rsp_count_d;
  logic               rsp_err_q, rsp_err_d;

  logic               mem_en, mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [POS_W-1:0]   mem_wdata, mem_rdata;

  logic [ADDR_W:0]    room, k_rw, slot;
  logic [LANE_W-1:0]  lane_sel, cap_sel;
  op_e                op;

  assign op       = op_e'(cmd_op_i);
  assign room     = DEPTH_X - {1'b0, cmd_addr_i};
  assign k_rw     = (room > LANES_X) ? LANES_X : room;
  assign slot     = {1'b0, base_q} + (ADDR_W+1)'(idx_q);
  assign lane_sel = LANE_W'(idx_q);
  assign cap_sel  = LANE_W'(idx_q - CNT_W'(1));
  assign mem_addr = ADDR_W'(slot);

  mem_single #(.WIDTH(POS_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  // Next-state, lane mux/demux, RAM control and response accumulation.
  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    rsp_count_d = rsp_count_q;
    rsp_err_d   = rsp_err_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          base_d     = cmd_addr_i;
          data_d     = cmd_data_i;
          idx_d      = '0;
          rsp_data_d = '0;
          if (({1'b0, cmd_addr_i} >= DEPTH_X) || (op == OP_RSVD)) begin
            rsp_count_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = ST_RESP;
          end else if (op == OP_FILL) begin
            cnt_d       = CNT_W'(room);
            rsp_count_d = CNT_W'(room);
            rsp_err_d   = 1'b0;
            state_d     = ST_FILL;
          end else begin
            cnt_d       = CNT_W'(k_rw);
            rsp_count_d = CNT_W'(k_rw);
            rsp_err_d   = (k_rw < LANES_X);
            state_d     = (op == OP_WRITE) ? ST_WRITE : ST_READ;
          end
        end
      end
      ST_WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = data_q[int'(lane_sel)*POS_W +: POS_W];
        rsp_data_d[int'(lane_sel)*POS_W +: POS_W] = mem_wdata;
        idx_d = idx_q + CNT_W'(1);
        if (idx_q == cnt_q - CNT_W'(1)) state_d = ST_RESP;
      end
      ST_READ: begin
        mem_en = 1'b1;
        // The word issued last cycle arrives now; it belongs to the previous lane.
        if (idx_q != '0) rsp_data_d[int'(cap_sel)*POS_W +: POS_W] = mem_rdata;
        idx_d = idx_q + CNT_W'(1);
        if (idx_q == cnt_q - CNT_W'(1)) state_d = ST_RDRAIN;
      end
      ST_RDRAIN: begin
        rsp_data_d[int'(cap_sel)*POS_W +: POS_W] = mem_rdata;
        state_d = ST_RESP;
      end
      ST_FILL: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = DUMMY_MARK | POS_W'(slot);
        idx_d     = idx_q + CNT_W'(1);
        if (idx_q == cnt_q - CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_data_d  = '0;
          rsp_count_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and response registers; reset aborts any command in flight.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_count_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_count_q <= rsp_count_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign busy_o      = (state_q != ST_IDLE);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_count_o = rsp_count_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_sparse_pos_loader.sv
// Scoreboard bench for sparse_pos_loader: a bench-side RAM model predicts each response.
module tb_sparse_pos_loader;
  import sparse_pos_loader_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [1:0]        cmd_op_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_data_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_data_o;
  logic [CNT_W-1:0]  rsp_count_o;
  logic              rsp_err_o;
  logic              busy_o;

  sparse_pos_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_data_i  (cmd_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_count_o (rsp_count_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  count;
    logic              err;
    int                lat;
  } exp_t;

  exp_t             exp_q[$];
  logic [POS_W-1:0] model [DEPTH];
  int               tests = 0;
  int               fails = 0;

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*POS_W +: POS_W] = POS_W'($urandom);
    return d;
  endfunction

  // Predict the response, update the model, then present the command for one cycle.
  // Returns at the first sample point after the accepting edge (cycle 1).
  task automatic send_cmd(input logic [1:0] op, input int addr,
                          input logic [DATA_W-1:0] data, input bit push);
    exp_t e;
    int   k;
    e.data = '0; e.count = '0; e.err = 1'b0; e.lat = 1;
    if (op == 2'b11 || addr >= DEPTH) begin
      e.err = 1'b1;
    end else if (op == 2'b10) begin
      k = DEPTH - addr;
      e.count = CNT_W'(k);
      e.lat   = k + 1;
      if (push) for (int j = 0; j < k; j++) model[addr+j] = DUMMY_MARK | POS_W'(addr + j);
    end else begin
      k = (DEPTH - addr > LANES) ? LANES : DEPTH - addr;
      e.count = CNT_W'(k);
      e.err   = (k < LANES);
      e.lat   = (op == 2'b00) ? k + 1 : k + 2;
      for (int j = 0; j < k; j++) begin
        if (op == 2'b00) begin
          model[addr+j] = data[j*POS_W +: POS_W];
          e.data[j*POS_W +: POS_W] = data[j*POS_W +: POS_W];
        end else begin
          e.data[j*POS_W +: POS_W] = model[addr+j];
        end
      end
    end
    if (push) exp_q.push_back(e);
    @(negedge clk);
    tests++;
    if (cmd_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL cmd_ready_idle got=%b want=1", cmd_ready_o);
    end
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_addr_i  = ADDR_W'(addr);
    cmd_data_i  = data;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    cmd_op_i    = 2'($urandom);
    cmd_addr_i  = ADDR_W'($urandom);
    cmd_data_i  = rand_data();
  endtask

  // Wait (bounded) for rsp_valid_o, pop the prediction and compare everything.
  task automatic wait_rsp(input string name, output exp_t e);
    int cyc = 1;
    while (rsp_valid_o !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    e.data = '0; e.count = '0; e.err = 1'b0; e.lat = 0;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s_scoreboard got=empty want=entry", name);
      return;
    end
    e = exp_q.pop_front();
    if (rsp_valid_o !== 1'b1 || cyc != e.lat) begin
      fails++;
      $display("FAIL %s_latency got=%0d(valid=%b) want=%0d", name, cyc, rsp_valid_o, e.lat);
    end
    tests++;
    if (rsp_data_o !== e.data) begin
      fails++;
      $display("FAIL %s_data got=%h want=%h", name, rsp_data_o, e.data);
    end
    tests++;
    if (rsp_count_o !== e.count) begin
      fails++;
      $display("FAIL %s_count got=%0d want=%0d", name, rsp_count_o, e.count);
    end
    tests++;
    if (rsp_err_o !== e.err) begin
      fails++;
      $display("FAIL %s_err got=%b want=%b", name, rsp_err_o, e.err);
    end
  endtask

  // Complete the response handshake and check that all rsp outputs cleared.
  task automatic handshake(input string name);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    tests++;
    if (rsp_valid_o !== 1'b0 || rsp_data_o !== '0 || rsp_count_o !== '0 ||
        rsp_err_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL %s_clear got=v%b c%0d e%b rdy%b want=v0 c0 e0 rdy1",
               name, rsp_valid_o, rsp_count_o, rsp_err_o, cmd_ready_o);
    end
  endtask

  task automatic do_cmd(input string name, input logic [1:0] op, input int addr,
                        input logic [DATA_W-1:0] data);
    exp_t e;
    send_cmd(op, addr, data, 1'b1);
    wait_rsp(name, e);
    handshake(name);
  endtask

  task automatic check_reset_vals(input string name);
    tests++;
    if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_data_o !== '0 ||
        rsp_count_o !== '0 || rsp_err_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL %s got=rdy%b v%b c%0d e%b busy%b want=rdy1 v0 c0 e0 busy0",
               name, cmd_ready_o, rsp_valid_o, rsp_count_o, rsp_err_o, busy_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_addr_i = '0;
    cmd_data_i = '0; rsp_ready_i = 1'b0;
    #1;
    check_reset_vals("reset_async");
    repeat (3) @(negedge clk);
    check_reset_vals("reset_held");
    rst_n = 1'b1;
  endtask

  task automatic test_write_full();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*POS_W +: POS_W] = POS_W'(i + 1);
    do_cmd("write_a0", 2'b00, 0, d);
  endtask

  task automatic test_read_full();
    do_cmd("read_a0", 2'b01, 0, rand_data());
  endtask

  task automatic test_preload();
    for (int a = 8; a < 72; a += 8) do_cmd("preload", 2'b00, a, rand_data());
    do_cmd("read_a40", 2'b01, 40, rand_data());
  endtask

  task automatic test_write_trunc();
    do_cmd("write_a70", 2'b00, 70, rand_data());
    do_cmd("read_a67", 2'b01, 67, rand_data());
  endtask

  task automatic test_fill();
    do_cmd("fill_a66", 2'b10, 66, rand_data());
    do_cmd("read_a58", 2'b01, 58, rand_data());
    do_cmd("read_a66", 2'b01, 66, rand_data());
    do_cmd("read_a72", 2'b01, 72, rand_data());
  endtask

  task automatic test_bad_addr();
    do_cmd("write_a80", 2'b00, 80, rand_data());
    do_cmd("rsvd_a0", 2'b11, 0, rand_data());
    do_cmd("fill_a127", 2'b10, 127, rand_data());
    do_cmd("read_a0_after_bad", 2'b01, 0, rand_data());
    do_cmd("read_a67_after_bad", 2'b01, 67, rand_data());
  endtask

  task automatic test_backpressure_reset();
    exp_t e;
    send_cmd(2'b00, 16, rand_data(), 1'b1);
    wait_rsp("hold_write", e);
    for (int i = 0; i < 20; i++) begin
      cmd_valid_i = i[0];
      cmd_op_i    = 2'($urandom);
      cmd_addr_i  = ADDR_W'($urandom_range(0, DEPTH - 1));
      @(negedge clk);
      tests++;
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== e.data || rsp_count_o !== e.count ||
          rsp_err_o !== e.err || cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin
        fails++;
        $display("FAIL hold_stable cyc=%0d got=v%b c%0d e%b rdy%b want=v1 c%0d e%b rdy0",
                 i, rsp_valid_o, rsp_count_o, rsp_err_o, cmd_ready_o, e.count, e.err);
      end
    end
    cmd_valid_i = 1'b0;
    handshake("hold_write");
    repeat (3) @(negedge clk);
    tests++;
    if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL hold_no_stray got=v%b busy%b want=v0 busy0", rsp_valid_o, busy_o);
    end
    // FILL from 0 aborted by reset after two slots have been written.
    send_cmd(2'b10, 0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid_fill");
    model[0] = DUMMY_MARK | POS_W'(0);
    model[1] = DUMMY_MARK | POS_W'(1);
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd("read_after_abort", 2'b01, 0, rand_data());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_full();
    test_read_full();
    test_preload();
    test_write_trunc();
    test_fill();
    test_bad_addr();
    test_backpressure_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
